// File: rtl/uart_tx_if.sv
// Byte-write handshake between the CPU side and the UART transmitter FIFO.
// A byte is transferred on a rising clk edge where wr_valid && wr_ready.
interface uart_tx_if;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;

    modport master (
        output wr_data,
        output wr_valid,
        input  wr_ready
    );

    modport slave (
        input  wr_data,
        input  wr_valid,
        output wr_ready
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: a small byte FIFO feeds a baud-timed FSM that drives tx,
// LSB first, with back-to-back frames whenever the FIFO still holds data.
module uart_tx #(
    parameter int CLK_FREQ_HZ = 12_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    uart_tx_if.slave                      wr,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int BCNT_W       = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [BCNT_W-1:0] BCNT_LAST  = BCNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_tx: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state;
    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [7:0]        shift;
    logic [2:0]        bit_idx;
    logic [BCNT_W-1:0] bcnt;
    logic              push;
    logic              pop;
    logic              bit_done;

    // Full-ness is decided by the count alone, so a pop in the same cycle cannot rescue a write.
    assign wr.wr_ready = (fifo_count != FULL_COUNT);
    assign push        = wr.wr_valid && wr.wr_ready;
    assign bit_done    = (bcnt == BCNT_LAST);
    assign pop         = (fifo_count != '0) &&
                         ((state == IDLE) || ((state == STOP) && bit_done));
    assign busy        = (state != IDLE) || (fifo_count != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W + 1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W + 1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage is not reset; clearing the pointers is enough to discard it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr.wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            shift   <= '0;
            bit_idx <= '0;
            bcnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        bcnt  <= '0;
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        bcnt    <= '0;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        bcnt <= bcnt + BCNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bcnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        bcnt <= bcnt + BCNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        bcnt <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            tx    <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        bcnt <= bcnt + BCNT_W'(1);
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    bcnt  <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 10 clocks per bit; a negedge line sampler decodes
// frames into rx_q, which is compared against hand-written expected byte lists.
module tb_uart_tx;

    logic       clk;
    logic       reset;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int assertions_evaluated = 0;
    int failures             = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    int         mon_cnt;
    logic       mon_active;
    logic [7:0] mon_byte;
    logic [7:0] t2_byte;
    logic       t2_exp;

    uart_tx_if wr_bus ();

    uart_tx #(
        .CLK_FREQ_HZ (1000),
        .BAUD_RATE   (100),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr_bus),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertions_evaluated++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Wait (bounded) for room in the FIFO, then present one byte for exactly one edge.
    task automatic applyStimulus(input logic [7:0] data);
        int n = 0;
        while (wr_bus.wr_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checkOutput("wr_ready_timeout", 32'(wr_bus.wr_ready), 32'd1);
        end
        wr_bus.wr_data  = data;
        wr_bus.wr_valid = 1'b1;
        @(negedge clk);
        wr_bus.wr_valid = 1'b0;
    endtask

    task automatic waitIdle(input int max_cycles);
        int n = 0;
        while (busy !== 1'b0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic checkReceived();
        checkOutput("rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checkOutput($sformatf("rx_byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
        end
    endtask

    // Line sampler: first low negedge is count 0, bit centres are at counts 5, 15, ..., 95.
    initial begin
        mon_active = 1'b0;
        mon_cnt    = 0;
        mon_byte   = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (tx === 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                end
            end else begin
                mon_cnt++;
                if (mon_cnt == 5) begin
                    checkOutput("start_bit", 32'(tx), 32'd0);
                end else if (mon_cnt >= 15 && mon_cnt <= 85 && (mon_cnt % 10) == 5) begin
                    mon_byte[3'((mon_cnt - 15) / 10)] = tx;
                end else if (mon_cnt == 95) begin
                    checkOutput("stop_bit", 32'(tx), 32'd1);
                    rx_q.push_back(mon_byte);
                    mon_active = 1'b0;
                end
            end
        end
    end

    initial begin
        reset           = 1'b0;
        wr_bus.wr_data  = '0;
        wr_bus.wr_valid = 1'b0;

        // Asynchronous reset takes effect between clock edges.
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("t1_tx", 32'(tx), 32'd1);
        checkOutput("t1_busy", 32'(busy), 32'd0);
        checkOutput("t1_wr_ready", 32'(wr_bus.wr_ready), 32'd1);
        checkOutput("t1_fifo_count", 32'(fifo_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single 0x55 frame, checked cycle by cycle.
        rx_q.delete();
        exp_q.delete();
        t2_byte = 8'h55;
        applyStimulus(t2_byte);
        checkOutput("t2_count_after_write", 32'(fifo_count), 32'd1);
        checkOutput("t2_tx_before_start", 32'(tx), 32'd1);
        for (int j = 1; j <= 101; j++) begin
            @(negedge clk);
            if (j <= 10)       t2_exp = 1'b0;
            else if (j <= 90)  t2_exp = t2_byte[3'((j - 11) / 10)];
            else               t2_exp = 1'b1;
            checkOutput($sformatf("t2_tx_cycle%0d", j), 32'(tx), 32'(t2_exp));
            if (j == 100) checkOutput("t2_busy_last_stop", 32'(busy), 32'd1);
            if (j == 101) checkOutput("t2_busy_after_stop", 32'(busy), 32'd0);
        end
        exp_q.push_back(8'h55);
        checkReceived();

        // Six consecutive writes: five fit, 0x06 is dropped.
        rx_q.delete();
        exp_q.delete();
        wr_bus.wr_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_bus.wr_data = 8'(i + 1);
            @(negedge clk);
        end
        wr_bus.wr_valid = 1'b0;
        checkOutput("t3_count_full", 32'(fifo_count), 32'd4);
        checkOutput("t3_wr_ready_full", 32'(wr_bus.wr_ready), 32'd0);

        // Write attempt on the edge where the first frame's STOP ends and pops.
        repeat (95) @(negedge clk);
        checkOutput("t4_count_before_pop", 32'(fifo_count), 32'd4);
        checkOutput("t4_wr_ready_before_pop", 32'(wr_bus.wr_ready), 32'd0);
        wr_bus.wr_data  = 8'hEE;
        wr_bus.wr_valid = 1'b1;
        @(negedge clk);
        wr_bus.wr_valid = 1'b0;
        checkOutput("t4_count_after_pop", 32'(fifo_count), 32'd3);
        checkOutput("t4_wr_ready_after_pop", 32'(wr_bus.wr_ready), 32'd1);
        waitIdle(600);
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        checkReceived();

        // Reset during DATA bit 3 of 0xA3 with two bytes queued.
        rx_q.delete();
        exp_q.delete();
        applyStimulus(8'hA3);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        repeat (43) @(negedge clk);
        checkOutput("t5_tx_bit3", 32'(tx), 32'd0);
        checkOutput("t5_count_queued", 32'(fifo_count), 32'd2);
        #2 reset = 1'b1;
        #1;
        checkOutput("t5_tx_reset", 32'(tx), 32'd1);
        checkOutput("t5_count_reset", 32'(fifo_count), 32'd0);
        checkOutput("t5_busy_reset", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("t5_tx_no_resume", 32'(tx), 32'd1);
        checkOutput("t5_busy_no_resume", 32'(busy), 32'd0);
        applyStimulus(8'h7E);
        waitIdle(300);
        exp_q.push_back(8'h7E);
        checkReceived();

        // Nine bytes through a four-entry FIFO exercise pointer wrap-around.
        rx_q.delete();
        exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(8'(8'h10 + i));
            exp_q.push_back(8'(8'h10 + i));
        end
        waitIdle(1500);
        checkReceived();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions_evaluated, failures);
        $finish;
    end

endmodule
